// File: rtl/int_pkg.sv
// Shared constants for the interrupt controller: source indices, FSM encoding
// and the fixed-priority encoder used by arbitration.
package int_pkg;

    localparam int NUM_SRC = 5;

    localparam logic [2:0] SRC_P1  = 3'd0;
    localparam logic [2:0] SRC_P2  = 3'd1;
    localparam logic [2:0] SRC_P3  = 3'd2;
    localparam logic [2:0] SRC_P4  = 3'd3;
    localparam logic [2:0] SRC_TMR = 3'd4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // Lowest set index wins; scanning downwards lets the lowest overwrite.
    function automatic logic [2:0] prio_enc(input logic [NUM_SRC-1:0] req);
        logic [2:0] idx;
        idx = SRC_P1;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_timer.sv
// Periodic tick source: a free-running prescaler feeding a reloadable period
// down-counter; tick_o pulses for one cycle each time the period elapses.
module int_timer #(
    parameter int PRESC = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tmr_we_i,
    input  logic [7:0] tmr_d_i,
    output logic       tick_o
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    period_q, period_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          wrap_s;

    assign wrap_s = (presc_q == PW'(PRESC - 1));
    assign tick_o = tick_q;

    // Next-state for prescaler, period register and period counter.
    always_comb begin
        presc_d  = presc_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        if (tmr_we_i) begin
            period_d = tmr_d_i;
            cnt_d    = tmr_d_i;
            presc_d  = '0;
        end else begin
            presc_d = wrap_s ? '0 : presc_q + PW'(1);
            if (wrap_s && (cnt_q != 8'd0)) begin
                if (cnt_q == 8'd1) begin
                    cnt_d  = period_q;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q  <= '0;
            period_q <= 8'd0;
            cnt_q    <= 8'd0;
            tick_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
        end
    end

endmodule

// File: rtl/int_controller.sv
// Prioritised, maskable, non-nesting interrupt controller: edge-detects four
// external lines plus a timer tick and hands one vector at a time to the CPU.
module int_controller
    import int_pkg::*;
#(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] VEC_BASE   = 10'h3E0,
    parameter int              VEC_STRIDE = 4,
    parameter int              PRESC      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      int_in,
    input  logic            mask_we,
    input  logic [4:0]      mask_d,
    input  logic            tmr_we,
    input  logic [7:0]      tmr_d,
    input  logic            ack,
    input  logic            fin_int,
    output logic            int_req,
    output logic [PC_W-1:0] int_vec,
    output logic [2:0]      int_src,
    output logic            in_service,
    output logic [4:0]      pending
);

    logic [3:0]      sync1_q, sync2_q, edge_q;
    logic [4:0]      pending_q, pending_d, mask_q, elig_s, clr_s;
    logic [1:0]      state_q, state_d;
    logic [2:0]      src_q, src_d, win_s;
    logic [PC_W-1:0] vec_q, vec_d;
    logic            req_q, svc_q, tick_s;
    logic [3:0]      edge_s;

    int_timer #(.PRESC(PRESC)) u_timer (
        .clk_i   (clk),
        .rst_i   (reset),
        .tmr_we_i(tmr_we),
        .tmr_d_i (tmr_d),
        .tick_o  (tick_s)
    );

    assign edge_s = sync2_q & ~edge_q;
    assign elig_s = pending_q & ~mask_q;
    assign win_s  = prio_enc(elig_s);

    // FSM next-state, source latch and pending update (new events beat clears).
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        vec_d   = vec_q;
        clr_s   = 5'b00000;
        case (state_q)
            ST_IDLE: begin
                if (elig_s != 5'b00000) begin
                    state_d = ST_REQ;
                    src_d   = win_s;
                    vec_d   = VEC_BASE + PC_W'(win_s) * PC_W'(VEC_STRIDE);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_d = ST_SERVICE;
                    clr_s   = 5'b00001 << src_q;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (fin_int) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pending_d = (pending_q & ~clr_s) | {tick_s, edge_s};
    end

    // State, synchroniser, mask and registered-output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 4'b0000;
            sync2_q   <= 4'b0000;
            edge_q    <= 4'b0000;
            pending_q <= 5'b00000;
            mask_q    <= 5'b00000;
            state_q   <= ST_IDLE;
            src_q     <= 3'd0;
            vec_q     <= '0;
            req_q     <= 1'b0;
            svc_q     <= 1'b0;
        end else begin
            sync1_q   <= int_in;
            sync2_q   <= sync1_q;
            edge_q    <= sync2_q;
            pending_q <= pending_d;
            mask_q    <= mask_we ? mask_d : mask_q;
            state_q   <= state_d;
            src_q     <= src_d;
            vec_q     <= vec_d;
            req_q     <= (state_d == ST_REQ);
            svc_q     <= (state_d == ST_SERVICE);
        end
    end

    assign int_req    = req_q;
    assign int_vec    = vec_q;
    assign int_src    = src_q;
    assign in_service = svc_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_int_controller.sv
// Scoreboard bench for int_controller: expected source/vector pairs are queued
// as events are injected and compared each time a request appears.
module tb_int_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] int_in;
    logic       mask_we;
    logic [4:0] mask_d;
    logic       tmr_we;
    logic [7:0] tmr_d;
    logic       ack;
    logic       fin_int;
    logic       int_req;
    logic [9:0] int_vec;
    logic [2:0] int_src;
    logic       in_service;
    logic [4:0] pending;

    typedef struct {
        logic [2:0] src;
        logic [9:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_cnt  = 0;
    int   last_req_cyc = 0;

    int_controller #(.PC_W(10), .VEC_BASE(10'h3E0), .VEC_STRIDE(4), .PRESC(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .int_in    (int_in),
        .mask_we   (mask_we),
        .mask_d    (mask_d),
        .tmr_we    (tmr_we),
        .tmr_d     (tmr_d),
        .ack       (ack),
        .fin_int   (fin_int),
        .int_req   (int_req),
        .int_vec   (int_vec),
        .int_src   (int_src),
        .in_service(in_service),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] src, input logic [9:0] vec);
        exp_t e;
        e.src = src;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_src"}, 32'(int_src), 32'(e.src));
            chk({tag, "_vec"}, 32'(int_vec), 32'(e.vec));
        end
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n;
        n = 0;
        while (int_req !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (int_req !== 1'b1) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            last_req_cyc = cyc_cnt;
            pop_cmp(tag);
        end
    endtask

    task automatic do_ack(input string tag, input int bit_i);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk({tag, "_svc"}, 32'(in_service), 32'd1);
        chk({tag, "_req_low"}, 32'(int_req), 32'd0);
        chk({tag, "_pend_clr"}, 32'(pending[bit_i]), 32'd0);
    endtask

    task automatic do_fin(input string tag);
        fin_int = 1'b1;
        @(negedge clk);
        fin_int = 1'b0;
        chk({tag, "_svc_end"}, 32'(in_service), 32'd0);
    endtask

    task automatic lines_low();
        int_in = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int   prev;
        logic saw;
        reset = 1'b1; int_in = 4'b0000; mask_we = 1'b0; mask_d = 5'b00000;
        tmr_we = 1'b0; tmr_d = 8'd0; ack = 1'b0; fin_int = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(int_req), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_vec", 32'(int_vec), 32'd0);
        chk("rst_svc", 32'(in_service), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single event on port 3, checking the synchroniser latency.
        int_in[2] = 1'b1;
        push_exp(3'd2, 10'h3E8);
        repeat (2) @(negedge clk);
        chk("t1_pend_early", 32'(pending), 32'd0);
        @(negedge clk);
        chk("t1_pend", 32'(pending), 32'h04);
        chk("t1_req_early", 32'(int_req), 32'd0);
        @(negedge clk);
        chk("t1_req", 32'(int_req), 32'd1);
        pop_cmp("t1");
        @(negedge clk);
        int_in[2] = 1'b0;
        do_ack("t1", 2);
        chk("t1_vec_held", 32'(int_vec), 32'h3E8);
        do_fin("t1");
        @(negedge clk);
        chk("t1_no_retrig", 32'(int_req), 32'd0);

        // Simultaneous events: priority, then 1-cycle gap.
        int_in = 4'b1001;
        push_exp(3'd0, 10'h3E0);
        push_exp(3'd3, 10'h3EC);
        wait_req("t2a", 10);
        do_ack("t2a", 0);
        do_fin("t2a");
        chk("t2_gap", 32'(int_req), 32'd0);
        @(negedge clk);
        chk("t2b_req", 32'(int_req), 32'd1);
        wait_req("t2b", 2);
        do_ack("t2b", 3);
        do_fin("t2b");
        lines_low();

        // Masked source stays pending until unmasked.
        mask_we = 1'b1; mask_d = 5'b00001;
        @(negedge clk);
        mask_we = 1'b0;
        int_in[0] = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (int_req === 1'b1) saw = 1'b1;
        end
        chk("t3_masked_req", 32'(saw), 32'd0);
        chk("t3_pend", 32'(pending), 32'h01);
        push_exp(3'd0, 10'h3E0);
        mask_we = 1'b1; mask_d = 5'b00000;
        @(negedge clk);
        mask_we = 1'b0;
        wait_req("t3", 5);
        do_ack("t3", 0);
        do_fin("t3");
        lines_low();

        // Timer: period 3 x prescaler 4 = one tick per 12 cycles.
        tmr_we = 1'b1; tmr_d = 8'd3;
        @(negedge clk);
        tmr_we = 1'b0;
        for (int k = 0; k < 3; k++) push_exp(3'd4, 10'h3F0);
        for (int k = 0; k < 3; k++) begin
            prev = last_req_cyc;
            wait_req("t4", 30);
            if (k > 0) chk("t4_interval", 32'(last_req_cyc - prev), 32'd12);
            @(negedge clk);
            do_ack("t4", 4);
            do_fin("t4");
        end
        tmr_we = 1'b1; tmr_d = 8'd0;
        @(negedge clk);
        tmr_we = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (int_req === 1'b1 || pending[4] === 1'b1) saw = 1'b1;
        end
        chk("t4_stopped", 32'(saw), 32'd0);

        // No nesting: higher-priority arrival during service waits.
        int_in[1] = 1'b1;
        push_exp(3'd1, 10'h3E4);
        push_exp(3'd0, 10'h3E0);
        wait_req("t5a", 10);
        do_ack("t5a", 1);
        int_in[0] = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (int_req === 1'b1) saw = 1'b1;
        end
        chk("t5_no_nest", 32'(saw), 32'd0);
        chk("t5_pend0", 32'(pending[0]), 32'd1);
        do_fin("t5a");
        wait_req("t5b", 4);
        do_ack("t5b", 0);
        do_fin("t5b");
        lines_low();

        // ack and fin_int together in REQ: ack wins.
        int_in[3] = 1'b1;
        push_exp(3'd3, 10'h3EC);
        wait_req("t6", 10);
        ack = 1'b1; fin_int = 1'b1;
        @(negedge clk);
        ack = 1'b0; fin_int = 1'b0;
        chk("t6_svc", 32'(in_service), 32'd1);
        do_fin("t6");
        lines_low();

        // Async reset while requesting.
        int_in[2] = 1'b1;
        push_exp(3'd2, 10'h3E8);
        wait_req("t7", 10);
        chk("t7_pend_pre", 32'(pending), 32'h04);
        reset = 1'b1;
        #1;
        chk("t7_req_rst", 32'(int_req), 32'd0);
        chk("t7_pend_rst", 32'(pending), 32'd0);
        chk("t7_vec_rst", 32'(int_vec), 32'd0);
        chk("t7_src_rst", 32'(int_src), 32'd0);
        int_in = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("t7_idle_after", 32'(int_req), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
